// File: rtl/programmable_timer_if.sv
//------------------------------------------------------------------------------
// Module : programmable_timer_if
// Brief  : Control/status bundle between a controller and programmable_timer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface programmable_timer_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
);
    logic             enable;
    logic             start;
    logic             stop;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] period_in;
    logic [PRE_W-1:0] prescale_in;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output enable, start, stop, mode, load, period_in, prescale_in,
        input  tick, count, busy, done
    );

    modport slave (
        input  enable, start, stop, mode, load, period_in, prescale_in,
        output tick, count, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/programmable_timer.sv
//------------------------------------------------------------------------------
// Module : programmable_timer
// Brief  : Run-time programmable periodic/one-shot timer with prescaler.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module programmable_timer #(
    parameter int WIDTH      = 8,
    parameter int PRE_W      = 8,
    parameter int PERIOD_RST = 255
) (
    input  wire                   clk,
    input  wire                   rst_n,
    programmable_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_period_rst = WIDTH'(PERIOD_RST);

    state_t           r_state;
    logic             r_mode;
    logic [WIDTH-1:0] r_period;
    logic [PRE_W-1:0] r_prescale;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_busy;
    logic             r_done;

    logic w_pre_wrap;
    logic w_terminal;

    assign w_pre_wrap = (r_pre_cnt == r_prescale);
    // >= so a period lowered below the current count ends on the next step
    assign w_terminal = (r_count >= r_period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= 1'b0;
            r_period   <= c_period_rst;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (bus.load) begin
                r_period   <= bus.period_in;
                r_prescale <= bus.prescale_in;
            end
            if (bus.stop) begin
                r_state   <= ST_IDLE;
                r_pre_cnt <= '0;
                r_count   <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
            end else if (bus.start) begin
                r_state   <= ST_RUN;
                r_mode    <= bus.mode;
                r_pre_cnt <= '0;
                r_count   <= '0;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
            end else if (r_state == ST_RUN && bus.enable) begin
                if (w_pre_wrap) begin
                    r_pre_cnt <= '0;
                    if (w_terminal) begin
                        r_count <= '0;
                        r_tick  <= 1'b1;
                        if (r_mode) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    r_pre_cnt <= r_pre_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.tick  = r_tick;
    assign bus.count = r_count;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_programmable_timer.sv
//------------------------------------------------------------------------------
// Module : tb_programmable_timer
// Brief  : Scoreboard bench: expected tick cycles queued at stimulus time.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_programmable_timer;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   exp_q[$];
    int   e0;

    programmable_timer_if #(.WIDTH(8), .PRE_W(8)) bus ();

    programmable_timer #(.WIDTH(8), .PRE_W(8), .PERIOD_RST(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every observed tick must match the oldest outstanding expected tick cycle
    always @(negedge clk) begin
        if (bus.tick) begin
            if (exp_q.size() == 0) check_eq("spurious_tick", cyc, -1);
            else check_eq("tick_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int p, input int s);
        bus.load        = 1'b1;
        bus.period_in   = 8'(p);
        bus.prescale_in = 8'(s);
        next_cycle();
        bus.load = 1'b0;
    endtask

    task automatic do_start(input logic m);
        bus.start = 1'b1;
        bus.mode  = m;
        e0 = cyc + 1;
        next_cycle();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        next_cycle();
        bus.stop = 1'b0;
    endtask

    task automatic drained(input string tag);
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc             = 0;
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.enable      = 1'b1;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.mode        = 1'b0;
        bus.load        = 1'b0;
        bus.period_in   = '0;
        bus.prescale_in = '0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Reset state, then default P=255/S=0 periodic run
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_tick", bus.tick, 0);
        do_start(1'b0);
        exp_q.push_back(e0 + 256);
        exp_q.push_back(e0 + 512);
        check_eq("start_busy", bus.busy, 1);
        check_eq("start_count", bus.count, 0);
        wait_until(e0 + 100);
        check_eq("def_count100", bus.count, 100);
        wait_until(e0 + 255);
        check_eq("def_count255", bus.count, 255);
        wait_until(e0 + 520);
        do_stop();
        check_eq("stop_count", bus.count, 0);
        check_eq("stop_busy", bus.busy, 0);
        drained("def_missed");

        // P=3, S=2: tick every 12 cycles, count steps every 3rd cycle
        do_load(3, 2);
        do_start(1'b0);
        for (int k = 1; k <= 3; k++) exp_q.push_back(e0 + 12 * k);
        wait_until(e0 + 7);
        check_eq("pre_count", bus.count, 2);
        wait_until(e0 + 40);
        do_stop();
        drained("pre_missed");

        // One-shot P=4, S=0, then rearm
        do_load(4, 0);
        for (int r = 0; r < 2; r++) begin
            do_start(1'b1);
            exp_q.push_back(e0 + 5);
            check_eq("os_busy_run", bus.busy, 1);
            check_eq("os_done_run", bus.done, 0);
            wait_until(e0 + 5);
            check_eq("os_done", bus.done, 1);
            check_eq("os_busy", bus.busy, 0);
            check_eq("os_count", bus.count, 0);
            wait_until(e0 + 15);
            check_eq("os_hold_count", bus.count, 0);
            check_eq("os_hold_done", bus.done, 1);
            drained("os_missed");
        end

        // Enable low for 7 cycles delays the tick by exactly 7
        do_load(9, 0);
        do_start(1'b0);
        exp_q.push_back(e0 + 17);
        exp_q.push_back(e0 + 27);
        wait_until(e0 + 3);
        bus.enable = 1'b0;
        wait_until(e0 + 10);
        check_eq("en_frozen_count", bus.count, 3);
        bus.enable = 1'b1;
        wait_until(e0 + 30);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        next_cycle();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check_eq("ss_busy", bus.busy, 0);
        check_eq("ss_count", bus.count, 0);
        repeat (15) next_cycle();
        check_eq("ss_idle_count", bus.count, 0);
        drained("en_missed");

        // Period lowered below current count terminates on the next step
        do_load(20, 0);
        do_start(1'b0);
        wait_until(e0 + 9);
        check_eq("bl_count9", bus.count, 9);
        exp_q.push_back(e0 + 11);
        exp_q.push_back(e0 + 17);
        exp_q.push_back(e0 + 23);
        do_load(5, 0);
        check_eq("bl_count10", bus.count, 10);
        wait_until(e0 + 11);
        check_eq("bl_wrap", bus.count, 0);
        wait_until(e0 + 25);
        do_stop();
        drained("bl_missed");

        // P=0, S=0: tick every cycle
        do_load(0, 0);
        do_start(1'b0);
        for (int k = 1; k <= 5; k++) exp_q.push_back(e0 + k);
        wait_until(e0 + 5);
        do_stop();
        drained("p0_missed");

        // Asynchronous reset mid-run, away from any clock edge
        do_load(9, 0);
        do_start(1'b0);
        wait_until(e0 + 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", bus.count, 0);
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_tick", bus.tick, 0);
        next_cycle();
        rst_n = 1'b1;
        repeat (20) next_cycle();
        check_eq("arst_idle_count", bus.count, 0);
        check_eq("arst_idle_busy", bus.busy, 0);
        do_start(1'b0);
        wait_until(e0 + 3);
        check_eq("arst_restart_count", bus.count, 3);
        do_stop();
        drained("arst_missed");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/programmable_timer.md
# programmable_timer

Parametrised, run-time programmable successor to the fixed-terminal counter timer. It produces a one-cycle `tick` every (period+1)×(prescale+1) enabled clock cycles, in periodic or one-shot mode. Start, stop, period load and status outputs let a controller FSM or a baud/refresh generator program it without resynthesis. It sits between system control logic and any block needing a timed strobe.

## Interface
Parameters:
- `WIDTH`, 8: width of the main counter and the period register.
- `PRE_W`, 8: width of the prescaler counter and the prescale register.
- `PERIOD_RST`, 255: period register value after reset; must be < 2^WIDTH.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  count-advance gate; low freezes both counters.
- `start`  input  1  pulse: enter RUN with both counters cleared.
- `stop`  input  1  pulse: enter IDLE, clear both counters.
- `mode`  input  1  0 = periodic, 1 = one-shot; sampled when `start` is accepted.
- `load`  input  1  write `period_in` and `prescale_in` to the registers.
- `period_in`  input  WIDTH  terminal count value.
- `prescale_in`  input  PRE_W  prescale divisor minus one.
- `tick`  output  1  registered one-cycle strobe at each terminal step.
- `count`  output  WIDTH  current main counter value.
- `busy`  output  1  high in RUN.
- `done`  output  1  high in DONE (one-shot has expired).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Register `mode_reg` latches `mode` on an accepted `start`.
- Define `step` = (state==RUN) && `enable` && (pre_cnt == prescale_reg).
- Prescaler: in RUN with `enable` high, pre_cnt wraps to 0 when it equals prescale_reg, else increments. Otherwise it holds.
- Main counter: on `step`, the counter is terminal when count >= period_reg. A terminal step sets count to 0, otherwise count increments.
  - Using >= means a period lowered below the current count terminates on the next step, with no wrap through 2^WIDTH.
- `tick` <= `step` && terminal, otherwise 0.
- Transitions:
  - IDLE/DONE/RUN → RUN on `start`. Counters clear and `mode_reg` is latched; `start` in RUN is a restart.
  - RUN → DONE on a terminal step when `mode_reg`=1. Count is 0; `tick` still fires.
  - RUN stays in RUN on a terminal step when `mode_reg`=0.
  - Any state → IDLE on `stop`. Counters clear.
- Priority: `stop` > `start` > counting. `load` is independent of all three.
- `load` updates period_reg and prescale_reg at the edge. A step in the same cycle compares against the old values.
- `enable` low freezes pre_cnt, count and `tick` generation. `start`, `stop` and `load` are still honoured.
- period_reg=0: every step is terminal. prescale_reg=0: every enabled RUN cycle is a step.

## Timing
- Reset values:
  - `tick`, `busy`, `done` = 0
  - `count` = 0, pre_cnt = 0
  - period_reg = `PERIOD_RST`, prescale_reg = 0, `mode_reg` = 0
- Assertion of `rst_n` clears everything immediately, mid-run included. Deassertion is used synchronously by the next edge.
- `start` sampled at edge E0 gives count=0 and `busy`=1 after E0.
- With prescale=0, period=P and `enable` held high, `tick` is high during the cycle after edge E0+P+1, and every P+1 cycles after that.
- General tick period = (P+1)×(S+1) enabled cycles.
- `tick` lasts exactly one cycle and never fires in IDLE or DONE.
- One-shot: `done` and `tick` rise at the same edge, and `busy` falls at that edge.
- `count` is a registered output with no combinational paths from inputs to outputs.

## Test plan
- Reset: after reset (P=255, S=0), `start`, enable=1 → first `tick` after 256 enabled cycles, then every 256 cycles; `count` runs 0..255.
- Prescale/period: load P=3, S=2, periodic start → `tick` every 12 cycles; `count` advances every 3rd cycle.
- One-shot: P=4, S=0, mode=1 → single `tick` 5 cycles after start. `done`=1, `busy`=0, `count`=0 held. A second `start` rearms.
- Enable/stop: toggle `enable` low for 7 cycles mid-run → tick shifts exactly 7 cycles later. `stop` together with `start` → IDLE, `count`=0, no `tick`.
- Boundary load: while count=9 with P=20, load P=5 → next step is terminal (`tick`, count→0). P=0, S=0 → `tick` every cycle.
- Async reset: assert `rst_n`=0 mid-cycle during RUN → all outputs 0 immediately, before any clock edge. Counting resumes only after a new `start`.
